// File: rtl/servo_ctrl_pkg.sv
// Shared definitions for the servo position-path controllers: state encoding
// and default geometry for the move scheduler.
`timescale 1ns/1ps
package servo_ctrl_pkg;
  localparam int OUT_W_DEF     = 8;
  localparam int SWEEP_MIN_DEF = 'h10;
  localparam int SWEEP_MAX_DEF = 'hF0;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_MANUAL     = 3'd1;
  localparam logic [2:0] ST_GOTO       = 3'd2;
  localparam logic [2:0] ST_SWEEP_UP   = 3'd3;
  localparam logic [2:0] ST_SWEEP_DOWN = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_MANUAL     = ST_MANUAL,
    S_GOTO       = ST_GOTO,
    S_SWEEP_UP   = ST_SWEEP_UP,
    S_SWEEP_DOWN = ST_SWEEP_DOWN
  } state_e;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous pad buttons.
`timescale 1ns/1ps
module sync2 (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/servo_move_sched.sv
// Motion scheduler: arbitrates pad, goto and sweep requesters onto one
// inc/dec position counter with rate-limited, mutually exclusive pulses.
//
// state        | meaning
// S_IDLE       | no motion, goto accepted, sweep may start
// S_MANUAL     | pad button(s) held, pads drive the counter
// S_GOTO       | moving toward latched target
// S_SWEEP_UP   | autonomous sweep, rising toward SWEEP_MAX
// S_SWEEP_DOWN | autonomous sweep, falling toward SWEEP_MIN
`timescale 1ns/1ps
module servo_move_sched
  import servo_ctrl_pkg::*;
#(
  parameter int               OUT_W     = OUT_W_DEF,
  parameter int               STEP_DIV  = 4,
  parameter logic [OUT_W-1:0] SWEEP_MIN = OUT_W'(SWEEP_MIN_DEF),
  parameter logic [OUT_W-1:0] SWEEP_MAX = OUT_W'(SWEEP_MAX_DEF)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             pad_up_i,
  input  logic             pad_down_i,
  input  logic             sweep_en_i,
  input  logic             goto_valid_i,
  input  logic [OUT_W-1:0] goto_pos_i,
  output logic             goto_ready_o,
  input  logic [OUT_W-1:0] pos_i,
  output logic             inc_o,
  output logic             dec_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             abort_o
);
  localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  state_e           state, state_nxt;
  logic [PS_W-1:0]  ps_cnt;
  logic [OUT_W-1:0] target;
  logic             up_s, down_s, manual_req, tick, accept;
  logic             want_inc, want_dec, done_nxt, abort_nxt;
  logic             at_max, at_min;

  sync2 u_sync_up   (.clk_i(clk_i), .rstn_i(rstn_i), .d(pad_up_i),   .q(up_s));
  sync2 u_sync_down (.clk_i(clk_i), .rstn_i(rstn_i), .d(pad_down_i), .q(down_s));

  assign manual_req = up_s | down_s;
  assign tick       = (ps_cnt == PS_W'(STEP_DIV - 1));
  assign at_max     = (pos_i == {OUT_W{1'b1}});
  assign at_min     = (pos_i == '0);
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else ps_cnt <= ps_cnt + PS_W'(1);
  end

  always_comb begin
    state_nxt    = state;
    want_inc     = 1'b0;
    want_dec     = 1'b0;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    goto_ready_o = ((state == S_IDLE) || (state == S_SWEEP_UP) ||
                    (state == S_SWEEP_DOWN)) && !manual_req;
    accept       = goto_valid_i && goto_ready_o;
    // Pads pre-empt everything; conflicting pads hold still.
    if (manual_req) begin
      state_nxt = S_MANUAL;
      abort_nxt = (state == S_GOTO);
      want_inc  = up_s && !down_s;
      want_dec  = down_s && !up_s;
    end else if (accept) begin
      state_nxt = S_GOTO;
    end else begin
      case (state)
        S_IDLE:   if (sweep_en_i) state_nxt = S_SWEEP_UP;
        S_MANUAL: state_nxt = sweep_en_i ? S_SWEEP_UP : S_IDLE;
        S_GOTO: begin
          if (pos_i < target) want_inc = 1'b1;
          else if (pos_i > target) want_dec = 1'b1;
          else begin
            done_nxt  = 1'b1;
            state_nxt = sweep_en_i ? S_SWEEP_UP : S_IDLE;
          end
        end
        S_SWEEP_UP: begin
          if (!sweep_en_i) state_nxt = S_IDLE;
          else if (pos_i >= SWEEP_MAX) state_nxt = S_SWEEP_DOWN;
          else want_inc = 1'b1;
        end
        S_SWEEP_DOWN: begin
          if (!sweep_en_i) state_nxt = S_IDLE;
          else if (pos_i <= SWEEP_MIN) state_nxt = S_SWEEP_UP;
          else want_dec = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= S_IDLE;
      target  <= '0;
      inc_o   <= 1'b0;
      dec_o   <= 1'b0;
      done_o  <= 1'b0;
      abort_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      if (accept) target <= goto_pos_i;
      inc_o   <= tick && want_inc && !at_max;
      dec_o   <= tick && want_dec && !at_min;
      done_o  <= done_nxt;
      abort_o <= abort_nxt;
    end
  end
endmodule
